// File: rtl/multicycle_ctrl_if.sv
// Control/memory handshake bundle between the multi-cycle sequencer and the datapath.
// The sequencer connects through the master modport; the datapath/memory side through slave.
// MULTICYCLE_CTRL_PERF_EN adds the instret/cycles performance counters to the bundle.
interface multicycle_ctrl_if;
  logic [31:0] inst;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel_data;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        halted;
  logic [1:0]  trap_cause;
  logic [2:0]  state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] instret;
  logic [31:0] cycles;

  modport master (
    input  inst, mem_ready, branch_taken,
    output mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src, reg_write, wb_sel,
    output halted, trap_cause, state, instret, cycles
  );
  modport slave (
    output inst, mem_ready, branch_taken,
    input  mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src, reg_write, wb_sel,
    input  halted, trap_cause, state, instret, cycles
  );
`else
  modport master (
    input  inst, mem_ready, branch_taken,
    output mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src, reg_write, wb_sel,
    output halted, trap_cause, state
  );
  modport slave (
    output inst, mem_ready, branch_taken,
    input  mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_src, reg_write, wb_sel,
    input  halted, trap_cause, state
  );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB], shared memory port
// with req/ready handshake and a wait-cycle watchdog that traps into HALT.
// Optional: define MULTICYCLE_CTRL_PERF_EN for the instret/cycles counters.
module multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  localparam int unsigned WaitW = ($clog2(WAIT_LIMIT + 1) > 4) ? $clog2(WAIT_LIMIT + 1) : 4;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_LIMIT - 1);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpL     = 7'b0000011;
  localparam logic [6:0] OpS     = 7'b0100011;
  localparam logic [6:0] OpB     = 7'b1100011;
  localparam logic [6:0] OpJ     = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpSys   = 7'b1110011;

  typedef enum logic [2:0] {
    StRst    = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [1:0]       trap_q, trap_d;

  logic [6:0] op;
  logic       is_legal;
  logic       pc_we;

  // Only the opcode field matters to the sequencer.
  logic unused_inst;
  assign unused_inst = ^bus.inst[31:7];
  assign op          = bus.inst[6:0];

  assign is_legal = (op == OpR) || (op == OpI) || (op == OpL) || (op == OpS) || (op == OpB) ||
                    (op == OpJ) || (op == OpJalr) || (op == OpLui) || (op == OpAuipc);

  // Next state, wait counter, trap latch and all decoded outputs.
  always_comb begin
    state_d           = state_q;
    wait_d            = wait_q;
    trap_d            = trap_q;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_sel_data  = 1'b0;
    bus.ir_we         = 1'b0;
    pc_we             = 1'b0;
    bus.pc_src        = 2'b00;
    bus.reg_write     = 1'b0;
    bus.wb_sel        = 2'b00;
    bus.halted        = 1'b0;
    bus.trap_cause    = 2'b00;
    unique case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_we = 1'b1;
          state_d   = StDecode;
        end else if (wait_q == WaitLast) begin
          state_d = StHalt;
          trap_d  = 2'b11;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        if (op == OpSys) begin
          state_d = StHalt;
          trap_d  = 2'b10;
        end else if (is_legal) begin
          state_d = StExec;
        end else begin
          state_d = StHalt;
          trap_d  = 2'b01;
        end
      end
      StExec: begin
        if (op == OpB) begin
          pc_we      = 1'b1;
          bus.pc_src = bus.branch_taken ? 2'b01 : 2'b00;
          state_d    = StFetch;
        end else if ((op == OpL) || (op == OpS)) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        bus.mem_req      = 1'b1;
        bus.mem_sel_data = 1'b1;
        bus.mem_we       = (op == OpS);
        if (bus.mem_ready) begin
          if (op == OpS) begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (wait_q == WaitLast) begin
          state_d = StHalt;
          trap_d  = 2'b11;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        bus.reg_write = 1'b1;
        pc_we         = 1'b1;
        state_d       = StFetch;
        if (op == OpL) begin
          bus.wb_sel = 2'b01;
        end else if ((op == OpJ) || (op == OpJalr)) begin
          bus.wb_sel = 2'b10;
        end else if (op == OpLui) begin
          bus.wb_sel = 2'b11;
        end
        if (op == OpJ) begin
          bus.pc_src = 2'b01;
        end else if (op == OpJalr) begin
          bus.pc_src = 2'b10;
        end
      end
      StHalt: begin
        bus.halted     = 1'b1;
        bus.trap_cause = trap_q;
      end
      default: state_d = StRst;
    endcase
    // Every state entry restarts the watchdog.
    if (state_d != state_q) begin
      wait_d = '0;
    end
  end

  assign bus.pc_we = pc_we;
  assign bus.state = state_q;

  // State, watchdog and trap-cause registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRst;
      wait_q  <= '0;
      trap_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycles_q, cycles_d, instret_q, instret_d;

  // Performance counters: active cycles and retired instructions, both wrapping.
  always_comb begin
    cycles_d  = cycles_q;
    instret_d = instret_q;
    if ((state_q != StRst) && (state_q != StHalt)) begin
      cycles_d = cycles_q + 32'd1;
    end
    if (pc_we) begin
      instret_d = instret_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end else begin
      cycles_q  <= cycles_d;
      instret_q <= instret_d;
    end
  end

  assign bus.cycles  = cycles_q;
  assign bus.instret = instret_q;
`endif

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the enables for the instruction register, PC, shared memory port and register-file write port (`regWrite`). It sits beside the decoder/register file and consumes the latched instruction's opcode and the ALU branch flag. Memory is one shared port with a req/ready handshake.

## Interface
- `WAIT_LIMIT`, default 15: maximum number of cycles `mem_req` may stay unanswered before the controller traps.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `inst` in 32: instruction register contents; valid from DECODE onward.
- `mem_ready` in 1: memory acknowledge; completes a transfer in any cycle where `mem_req`=1.
- `branch_taken` in 1: ALU comparison result, sampled in EXEC.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write strobe, stores only.
- `mem_sel_data` out 1: memory address source; 0 = PC, 1 = ALU result.
- `ir_we` out 1: load the instruction register.
- `pc_we` out 1: update the PC.
- `pc_src` out 2: next PC; 00 = PC+4, 01 = PC+imm, 10 = (rs1+imm)&~1.
- `reg_write` out 1: register-file write enable.
- `wb_sel` out 2: writeback source; 00 = ALU, 01 = memory data, 10 = PC+4, 11 = imm.
- `halted` out 1: core stopped.
- `trap_cause` out 2: 00 = none, 01 = illegal opcode, 10 = ecall/ebreak, 11 = memory timeout.
- `state` out 3: current state encoding, for debug.

## Operation
- States and encodings: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Outputs are Moore outputs decoded from `state`. The exceptions are `ir_we` and FETCH/MEM completion, which are gated with `mem_ready`.
- RST: all outputs 0. Next state is FETCH.
- FETCH:
  - Drive `mem_req`=1 and `mem_sel_data`=0.
  - On `mem_ready`: `ir_we`=1, go to DECODE.
- DECODE: classify `inst[6:0]`.
  - Recognised opcodes: R, I, L, S, B, J, JALR, LUI, AUIPC → EXEC.
  - 1110011 → HALT with cause 10.
  - Any other opcode → HALT with cause 01.
- EXEC:
  - R, I, LUI, AUIPC, J, JALR → WB.
  - L, S → MEM.
  - B → FETCH, with `pc_we`=1 and `pc_src` = `branch_taken` ? 01 : 00.
- MEM:
  - Drive `mem_req`=1, `mem_sel_data`=1, and `mem_we`=1 for S.
  - On `mem_ready`: S → FETCH with `pc_we`=1, `pc_src`=00; L → WB.
- WB: `reg_write`=1 and `pc_we`=1, then → FETCH.
  - `wb_sel`: R/I → 00; L → 01; J/JALR → 10; LUI → 11; AUIPC → 00.
  - `pc_src`: J → 01; JALR → 10; all others → 00.
- HALT: terminal until reset. `halted`=1, `trap_cause` is held, and every other enable is 0.
- Wait counter:
  - 4-bit-or-wider counter, cleared on every state entry.
  - Increments each FETCH/MEM cycle with `mem_ready`=0.
  - Reaching `WAIT_LIMIT` → HALT with cause 11.
  - `mem_ready` arriving in the same cycle the limit is reached wins; the transfer completes.
- The opcode is re-read from `inst` each cycle. The instruction register must be stable from DECODE through WB; it is only written under `ir_we`.
- x0 protection stays in the register file; the controller asserts `reg_write` regardless of rd.

## Timing
- Reset deasserted: RST for 1 cycle, then FETCH.
- Asserting `rst` mid-instruction forces RST immediately and clears all outputs asynchronously.
- Latency with zero-wait memory (`mem_ready`=1 in the request cycle):
  - R/I/U/J/JALR: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each wait cycle adds 1 to the latency.
- `mem_req` stays high, with a stable address select, until `mem_ready` arrives. It drops in the cycle after acceptance.
- `pc_we` is asserted in exactly one cycle per retired instruction.

## Configuration
- `MULTICYCLE_CTRL_PERF_EN` defined:
  - Adds outputs `instret` (32) and `cycles` (32).
  - Both reset to 0 and wrap modulo 2^32.
  - `cycles` increments every cycle outside RST and HALT.
  - `instret` increments on each `pc_we`.
- `MULTICYCLE_CTRL_PERF_EN` undefined: both ports and both counters are absent.

## Test plan
- `add` (0x002081B3), zero-wait memory → states 1,2,3,5,1. `reg_write`=1 only in WB with `wb_sel`=00. Exactly one `pc_we` with `pc_src`=00.
- `lw` (0x0000A103), `mem_ready` delayed 3 cycles in MEM → MEM lasts 4 cycles with `mem_sel_data`=1 and `mem_we`=0. Then WB with `wb_sel`=01. Total 8 cycles.
- `beq`, run twice: `branch_taken`=1 → `pc_src`=01; `branch_taken`=0 → `pc_src`=00. No `reg_write` in either case. 3 cycles each.
- `jalr` (0x000080E7) → WB with `wb_sel`=10 and `pc_src`=10. Opcode 0x7F → HALT with `trap_cause`=01. Any `ecall` → `trap_cause`=10. `halted` stays 1 until `rst` goes low.
- `mem_ready` held 0 in FETCH with `WAIT_LIMIT`=15 → HALT on the 15th wait cycle with `trap_cause`=11. Asserting `rst` mid-MEM → all outputs 0 immediately; FETCH one cycle after release.
